// File: rtl/ram_sdp_param_pkg.sv
// Shared constants for the simple-dual-port RAM: read-during-write modes and
// the clear-engine state encoding.
package ram_pkg;

  localparam int unsigned RDW_OLD = 0;
  localparam int unsigned RDW_NEW = 1;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/ram_sdp_param_if.sv
// Port bundle for ram_sdp_param: clear request/status, byte-masked write port
// and registered read port. The RAM sits on the slave side.
interface ram_sdp_param_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 6
);

  localparam int unsigned BE_W = DATA_W / 8;

  logic              init_start;
  logic              init_busy;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [BE_W-1:0]   wbe;
  logic              re;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;

  modport master (
    output init_start, we, waddr, wdata, wbe, re, raddr,
    input  init_busy, rdata, rvalid
  );

  modport slave (
    input  init_start, we, waddr, wdata, wbe, re, raddr,
    output init_busy, rdata, rvalid
  );

endinterface

// File: rtl/ram_sdp_param_clear_ctrl.sv
// Clear engine for ram_sdp_param: walks every word once after reset or on
// request, owning the write port while busy and gating user traffic.
module ram_clear_ctrl
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_start,
  output logic              init_busy,
  output logic              user_en,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  clr_state_e        state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLR_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A start request in IDLE also masks that cycle's user read/write.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    init_busy = 1'b0;
    user_en   = 1'b0;
    clr_we    = 1'b0;
    case (state)
      CLR_IDLE: begin
        if (init_start) begin
          state_nxt = CLR_CLEAR;
          cnt_nxt   = '0;
        end else begin
          user_en = 1'b1;
        end
      end
      CLR_CLEAR: begin
        init_busy = 1'b1;
        clr_we    = 1'b1;
        if (cnt == LAST_ADDR) begin
          state_nxt = CLR_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = CLR_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign clr_addr = cnt;

endmodule

// File: rtl/ram_sdp_param.sv
// Parametrised simple-dual-port RAM with byte-masked writes, registered read
// data, selectable read-during-write and a built-in clear engine.
// Define RAM_OUT_REG_EN for a second output register stage (read latency 2).
module ram_sdp_param
  import ram_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned RDW_MODE = RDW_OLD
) (
  input  logic            clk,
  input  logic            rst_n,
  ram_sdp_param_if.slave  bus
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_X;
  endfunction

  function automatic logic [DATA_W-1:0] be_merge(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [BE_W-1:0]   be
  );
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int unsigned i = 0; i < BE_W; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  logic              user_en;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              busy;

  ram_clear_ctrl #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clear_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_start (bus.init_start),
    .init_busy  (busy),
    .user_en    (user_en),
    .clr_we     (clr_we),
    .clr_addr   (clr_addr)
  );

  assign bus.init_busy = busy;

  // Write port: clear engine has priority; out-of-range user writes are dropped.
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [BE_W-1:0]   wr_be;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    wr_be   = '0;
    if (clr_we) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr;
      wr_be   = '1;
    end else if (user_en && bus.we && in_range(bus.waddr)) begin
      wr_en   = 1'b1;
      wr_addr = bus.waddr;
      wr_data = bus.wdata;
      wr_be   = bus.wbe;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (wr_be[i]) mem[wr_addr[IDX_W-1:0]][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Read port: the array is sampled before the edge, so the stored word is
  // the pre-write value; new-data mode merges the write bytes in front of it.
  logic              rd_en;
  logic              rd_hit;
  logic              rd_coll;
  logic [DATA_W-1:0] rd_old;
  logic [DATA_W-1:0] rd_word;

  assign rd_en   = user_en & bus.re;
  assign rd_hit  = in_range(bus.raddr);
  assign rd_old  = rd_hit ? mem[bus.raddr[IDX_W-1:0]] : '0;
  assign rd_coll = user_en & bus.we & rd_hit & (bus.waddr == bus.raddr);

  always_comb begin
    rd_word = rd_old;
    if (RDW_MODE == RDW_NEW && rd_coll) rd_word = be_merge(rd_old, bus.wdata, bus.wbe);
  end

  logic [DATA_W-1:0] rdata1;
  logic              rvalid1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata1  <= '0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid1 <= rd_en;
      if (rd_en) rdata1 <= rd_word;
    end
  end

`ifdef RAM_OUT_REG_EN
  logic [DATA_W-1:0] rdata2;
  logic              rvalid2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata2  <= '0;
      rvalid2 <= 1'b0;
    end else begin
      rvalid2 <= rvalid1 & ~busy;
      if (rvalid1) rdata2 <= rdata1;
    end
  end

  assign bus.rdata  = rdata2;
  assign bus.rvalid = rvalid2 & ~busy;
`else
  assign bus.rdata  = rdata1;
  assign bus.rvalid = rvalid1;
`endif

endmodule

// File: doc/ram_sdp_param.md
Name: ram_sdp_param

Overview:
- Parametrised simple-dual-port synchronous RAM: one write port and one read port, both on one clock, usable in the same cycle.
- Read data is registered and qualified by a valid strobe.
- Writes are byte-masked.
- Read-during-write behaviour at the same address is selectable.
- A built-in clear engine zeroes the whole array after reset or on request.
- Serves as the generic storage primitive for buffers and lookup tables across the design.

Parameters:
- DATA_W, 16, data width in bits; must be a multiple of 8.
- ADDR_W, 6, address width in bits.
- DEPTH, 64, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W.
- RDW_MODE, 0, same-address read-during-write: 0 = old data, 1 = new data.
- Derived constant BE_W = DATA_W/8.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- init_start  in  1  one-cycle pulse requesting a full-array clear.
- init_busy  out  1  high while the clear is running.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- wbe  in  BE_W  byte enables; bit i covers wdata[8i+7:8i].
- re  in  1  read enable.
- raddr  in  ADDR_W  read address.
- rdata  out  DATA_W  registered read data.
- rvalid  out  1  rdata valid strobe.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rdata=0, rvalid=0, clear counter=0, FSM=CLEAR.
  - init_busy=1 while rst_n is low.
  - Array contents are not reset directly; the clear pass zeroes them.
- FSM CLEAR:
  - Each cycle writes 0 to word[cnt], then cnt++.
  - At cnt==DEPTH-1: write that word, go to IDLE; init_busy drops the following cycle.
  - A full clear takes exactly DEPTH cycles.
  - During CLEAR, we/re/init_start are ignored and rvalid stays 0.
- FSM IDLE:
  - init_start=1 -> CLEAR with cnt=0.
  - If we or re is asserted in the same cycle as init_start, they are ignored.
- Write (IDLE, we=1):
  - Bytes with wbe[i]=1 are updated at the clock edge; other bytes are unchanged.
  - wbe=0 is a no-op.
- Read (IDLE, re=1):
  - rdata=mem[raddr] and rvalid=1 at the next edge (latency 1).
  - re=0: rvalid=0 next cycle; rdata holds its last value.
- Read and write to different addresses in the same cycle: fully independent.
- Same-address collision (we and re, waddr==raddr):
  - RDW_MODE=0: rdata = pre-write word.
  - RDW_MODE=1: rdata = merged word (new bytes where wbe=1, old bytes elsewhere).
- Out-of-range address (addr >= DEPTH):
  - Write is dropped.
  - Read returns 0 with rvalid=1.
- Reset asserted mid-clear: outputs go to reset values immediately; on release the clear restarts from address 0.

Optional Feature:
- Macro: RAM_OUT_REG_EN.
- Defined:
  - Adds a second output register stage; read latency is 2.
  - rvalid is pipelined identically.
  - Both stages reset to 0.
  - A collision result is carried through unchanged.
  - During CLEAR, the stage-2 valid is forced to 0.
- Undefined: latency 1 as described above.

Decomposition:
- Package ram_pkg:
  - RDW_OLD=0, RDW_NEW=1 constants.
  - Clear-FSM state encoding (IDLE, CLEAR).
- One sub-module ram_clear_ctrl: FSM, address counter, init_busy, and the clear write strobe/address that are muxed onto the write port.

Test Plan:
- Release rst_n -> init_busy=1 for exactly 64 cycles, then 0; read 0x3F -> rvalid=1, rdata=0x0000.
- Write 0xA5C3 to 0x10, wbe=2'b11; then re with raddr=0x10 -> next cycle rdata=0xA5C3, rvalid=1.
- Then write 0x1122 to 0x10, wbe=2'b01; read 0x10 -> rdata=0xA522.
- mem[0x20]=0x0001; same cycle we (wdata=0xBEEF, wbe=2'b11) and re, both at 0x20:
  - RDW_MODE=0 -> rdata=0x0001.
  - RDW_MODE=1 -> rdata=0xBEEF.
  - Subsequent read -> 0xBEEF in both modes.
- Pulse rst_n low at cycle 30 of the clear -> rdata=0 and rvalid=0 immediately; after release init_busy lasts a full 64 cycles; mem[0x05] reads 0.
- With RAM_OUT_REG_EN defined: re at cycle N on address 0x10 holding 0xA522 -> rvalid=1 and rdata=0xA522 at cycle N+2, rvalid=0 at N+1.
